// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline hazard logic: FSM state codes,
// forwarding-select encodings and the default halting syscall code.
package pipeline_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [31:0] HALT_CODE_DEFAULT = 32'd10;

    // Register $0 is hardwired, so it never takes a bypass; memory beats writeback.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic [4:0] wr_m,
        input logic       we_m,
        input logic [4:0] wr_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0 && src == wr_m && we_m)
            sel = FWD_MEM;
        else if (src != 5'd0 && src == wr_w && we_w)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Bypass selection for a pair of source operands against the memory
// and writeback destinations.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] i_src_a,
    input  logic [4:0] i_src_b,
    input  logic [4:0] i_write_reg_m,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_write_reg_w,
    input  logic       i_reg_write_w,
    output logic [1:0] o_sel_a,
    output logic [1:0] o_sel_b
);

    assign o_sel_a = fwd_select(i_src_a, i_write_reg_m, i_reg_write_m,
                                i_write_reg_w, i_reg_write_w);
    assign o_sel_b = fwd_select(i_src_b, i_write_reg_m, i_reg_write_m,
                                i_write_reg_w, i_reg_write_w);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard unit: operand forwarding, load-use and branch stalls,
// and the syscall drain/service/halt sequencer.
module hazard_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned  DRAIN_CYCLES = 3,
    parameter logic [31:0]  HALT_CODE    = HALT_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        branch_d,
    input  logic        syscall_d,
    input  logic [4:0]  rs_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  write_reg_e,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic [4:0]  write_reg_m,
    input  logic [4:0]  write_reg_w,
    input  logic        reg_write_m,
    input  logic        mem_to_reg_m,
    input  logic        reg_write_w,
    input  logic [31:0] syscall_code,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        forward_ad,
    output logic        forward_bd,
    output logic [1:0]  forward_ae,
    output logic [1:0]  forward_be,
    output logic        syscall_go,
    output logic        halted
);

    logic [1:0] r_state;
    logic [2:0] r_cnt;

    logic [1:0] w_sel_ad;
    logic [1:0] w_sel_bd;
    logic       w_lw_stall;
    logic       w_br_stall;
    logic       w_hazard;
    logic       w_drain_done;
    logic       w_stall;
    logic       w_flush;
    logic       w_go;
    logic       w_halt;

    // Decode comparator only bypasses from memory, so writeback is tied off.
    forward_unit u_fwd_decode (
        .i_src_a       (rs_d),
        .i_src_b       (rt_d),
        .i_write_reg_m (write_reg_m),
        .i_reg_write_m (reg_write_m),
        .i_write_reg_w (5'd0),
        .i_reg_write_w (1'b0),
        .o_sel_a       (w_sel_ad),
        .o_sel_b       (w_sel_bd)
    );

    forward_unit u_fwd_execute (
        .i_src_a       (rs_e),
        .i_src_b       (rt_e),
        .i_write_reg_m (write_reg_m),
        .i_reg_write_m (reg_write_m),
        .i_write_reg_w (write_reg_w),
        .i_reg_write_w (reg_write_w),
        .o_sel_a       (forward_ae),
        .o_sel_b       (forward_be)
    );

    assign forward_ad = (w_sel_ad == FWD_MEM);
    assign forward_bd = (w_sel_bd == FWD_MEM);

    assign w_lw_stall = mem_to_reg_e & ((rt_e == rs_d) | (rt_e == rt_d));
    assign w_br_stall = branch_d &
                        ((reg_write_e  & ((write_reg_e == rs_d) | (write_reg_e == rt_d))) |
                         (mem_to_reg_m & ((write_reg_m == rs_d) | (write_reg_m == rt_d))));
    assign w_hazard   = w_lw_stall | w_br_stall;

    assign w_drain_done = ({29'd0, r_cnt} + 32'd1) >= DRAIN_CYCLES;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (syscall_d && !w_hazard) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= 3'd0;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done)
                        r_state <= ST_SERVICE;
                    if (r_cnt != 3'd7)
                        r_cnt <= r_cnt + 3'd1;
                end
                ST_SERVICE: begin
                    r_state <= (syscall_code == HALT_CODE) ? ST_HALT : ST_RUN;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    // Reset masks every control output so nothing fires during the reset cycle.
    always_comb begin
        w_stall = 1'b0;
        w_flush = 1'b0;
        w_go    = 1'b0;
        w_halt  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    w_stall = w_hazard | syscall_d;
                    w_flush = w_hazard | syscall_d;
                end
                ST_DRAIN: begin
                    w_stall = 1'b1;
                    w_flush = 1'b1;
                end
                ST_SERVICE: begin
                    w_flush = 1'b1;
                    w_go    = 1'b1;
                end
                default: begin
                    w_stall = 1'b1;
                    w_flush = 1'b1;
                    w_halt  = 1'b1;
                end
            endcase
        end
    end

    assign stall_f    = w_stall;
    assign stall_d    = w_stall;
    assign flush_e    = w_flush;
    assign syscall_go = w_go;
    assign halted     = w_halt;

endmodule
